mem_arbiter: RTL and testbench

- Shares one single-port memory_unit-style RAM between NUM_REQ requesters (e.g. instruction fetch and load/store).
- The RAM has a combinational read and a synchronous write on posedge.
- This block arbitrates, muxes address, write data and write enable to the RAM, and returns registered read data with a one-cycle ack per requester.
- It sits between the CPU datapath ports and the memory array.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter_rr_pick.sv | 62 ++++++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter and the RAM
// it fronts (memory_unit is instantiated with the same widths).
//
// Contents:
//   state_e     - arbiter FSM encoding (IDLE=0, ACCESS=1)
//   MEM_ARB_DW  - default data word width
//   MEM_ARB_AW  - default address width
package mem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam int MEM_ARB_DW = 8;
    localparam int MEM_ARB_AW = 8;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational winner selection for mem_arbiter.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority.
//
// Ports:
//   elig   [NUM_REQ-1:0] in  - requesters allowed to win this cycle
//   last   [IDXW-1:0]    in  - previous winner (round-robin only)
//   winner [IDXW-1:0]    out - selected requester index
//   found                out - at least one requester was eligible
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDXW    = 1
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [IDXW-1:0]    last,
    output logic [IDXW-1:0]    winner,
    output logic               found
);

`ifdef MEM_ARB_FIXED_PRIO_EN

    // The pointer has no meaning under fixed priority.
    logic unused_last;
    assign unused_last = ^last;

    // Lowest eligible index wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && elig[i]) begin
                found  = 1'b1;
                winner = IDXW'(i);
            end
        end
    end

`else

    // Search last+1 .. NUM_REQ-1 first, then wrap to 0 .. last.
    // Two ascending passes give the same order as a modulo walk.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && elig[i] && (IDXW'(i) > last)) begin
                found  = 1'b1;
                winner = IDXW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && elig[i] && (IDXW'(i) <= last)) begin
                found  = 1'b1;
                winner = IDXW'(i);
            end
        end
    end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port RAM (comb read, posedge write).
// Build option: MEM_ARB_FIXED_PRIO_EN (fixed priority, no pointer).
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req/we [NUM_REQ]    - per-requester request and write flag
//   addr/wdata (packed) - requester i at [i*W +: W]
//   gnt [NUM_REQ]       - one-hot, high in the ACCESS cycle
//   ack [NUM_REQ]       - one-hot pulse, cycle after ACCESS
//   rdata               - registered read data, valid with ack
//   mem_addr/mem_wdata/mem_write/mem_rdata - RAM side
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int DATAWIDTH = MEM_ARB_DW,
    parameter int ADDRWIDTH = MEM_ARB_AW
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             we,
    input  logic [NUM_REQ*ADDRWIDTH-1:0]   addr,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             ack,
    output logic [DATAWIDTH-1:0]           rdata,
    output logic [ADDRWIDTH-1:0]           mem_addr,
    output logic [DATAWIDTH-1:0]           mem_wdata,
    output logic                           mem_write,
    input  logic [DATAWIDTH-1:0]           mem_rdata
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e                 state_q, state_d;
    logic [IDXW-1:0]        sel_q, sel_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [DATAWIDTH-1:0]   rdata_q, rdata_d;

    logic [NUM_REQ-1:0]     elig;
    logic [NUM_REQ-1:0]     cand;
    logic [NUM_REQ-1:0]     sel_oh;
    logic [NUM_REQ-1:0]     win_oh;
    logic [IDXW-1:0]        win;
    logic                   found;
    logic [IDXW-1:0]        pick_last;

    logic [ADDRWIDTH-1:0]   bus_addr;
    logic [DATAWIDTH-1:0]   bus_wdata;
    logic                   bus_we;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign pick_last = '0;
`else
    logic [IDXW-1:0]        last_q, last_d;
    assign pick_last = last_q;
`endif

    assign sel_oh = NUM_REQ'(1) << sel_q;
    assign win_oh = NUM_REQ'(1) << win;

    // A requester is masked during its own ack cycle so a req still
    // high while the requester reacts to ack is not served twice.
    assign elig = req & ~ack_q;

    // The requester being served now cannot win the next slot.
    assign cand = (state_q == ACCESS) ? (elig & ~sel_oh) : elig;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_pick (
        .elig    (cand),
        .last    (pick_last),
        .winner  (win),
        .found   (found)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = '0;
        ack_d   = '0;
        rdata_d = rdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = ACCESS;
                    sel_d   = win;
                    gnt_d   = win_oh;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last_d  = win;
`endif
                end
            end
            ACCESS: begin
                // Loaded on writes too: old array contents.
                rdata_d = mem_rdata;
                ack_d   = sel_oh;
                if (found) begin
                    sel_d   = win;
                    gnt_d   = win_oh;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last_d  = win;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM-side mux; bus parks at zero outside ACCESS.
    always_comb begin
        bus_addr  = '0;
        bus_wdata = '0;
        bus_we    = 1'b0;
        if (state_q == ACCESS) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (sel_q == IDXW'(i)) begin
                    bus_addr  = addr[i*ADDRWIDTH +: ADDRWIDTH];
                    bus_wdata = wdata[i*DATAWIDTH +: DATAWIDTH];
                    bus_we    = we[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            // Requester 0 wins the first search.
            last_q  <= IDXW'(NUM_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign mem_addr  = bus_addr;
    assign mem_wdata = bus_wdata;
    // No RAM write may land on a reset edge.
    assign mem_write = bus_we & ~rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Expected values are hand-derived; RAM is a behavioural array.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  ack;
    logic [7:0]  rdata;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_write;
    logic [7:0]  mem_rdata;

    logic [7:0]  ram [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(
        .NUM_REQ   (2),
        .DATAWIDTH (8),
        .ADDRWIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];
    always @(posedge clk)
        if (mem_write) ram[mem_addr] <= mem_wdata;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // A granted requester must keep req high through ACCESS.
    always @(negedge clk)
        if (!rst && (gnt != 2'b00))
            check("req_hold", {30'd0, gnt & ~req}, 32'd0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic r, input logic w,
                           input logic [7:0] a, input logic [7:0] d);
        req[i]          = r;
        we[i]           = w;
        addr[i*8 +: 8]  = a;
        wdata[i*8 +: 8] = d;
    endtask

    logic [1:0] exp_gnt [6];
    logic [1:0] exp_ack [6];
    logic [7:0] exp_rd  [6];

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[8'h10] = 8'hA5;
        ram[8'h40] = 8'h77;
        rst   = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        step();
        step();

        // Reset state
        check("rst_gnt",   {30'd0, gnt},  32'd0);
        check("rst_ack",   {30'd0, ack},  32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        check("rst_mw",    {31'd0, mem_write}, 32'd0);
        rst = 1'b0;

        // 1: single read, latency 2
        set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
        step();
        check("t1_gnt",  {30'd0, gnt}, 32'd1);
        check("t1_ack0", {30'd0, ack}, 32'd0);
        check("t1_addr", {24'd0, mem_addr}, 32'h10);
        step();
        check("t1_ack",   {30'd0, ack}, 32'd1);
        check("t1_rdata", {24'd0, rdata}, 32'hA5);
        check("t1_gnt0",  {30'd0, gnt}, 32'd0);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        step();

        // 2: write then read back
        set_req(0, 1'b1, 1'b1, 8'h20, 8'h3C);
        step();
        check("t2_gnt", {30'd0, gnt}, 32'd1);
        check("t2_mw1", {31'd0, mem_write}, 32'd1);
        check("t2_wd",  {24'd0, mem_wdata}, 32'h3C);
        step();
        check("t2_ack", {30'd0, ack}, 32'd1);
        check("t2_mw0", {31'd0, mem_write}, 32'd0);
        check("t2_ram", {24'd0, ram[8'h20]}, 32'h3C);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        check("idle_addr", {24'd0, mem_addr}, 32'd0);
        check("idle_wd",   {24'd0, mem_wdata}, 32'd0);
        set_req(0, 1'b1, 1'b0, 8'h20, 8'h00);
        step();
        step();
        check("t2_rack",  {30'd0, ack}, 32'd1);
        check("t2_rdata", {24'd0, rdata}, 32'h3C);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        step();

        // 3: both held from reset; each ack cycle masks its owner
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
        set_req(1, 1'b1, 1'b0, 8'h20, 8'h00);
        exp_gnt = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
        exp_ack = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
        exp_rd  = '{8'h00, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 8'h3C};
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("t3_gnt%0d", k), {30'd0, gnt},
                  {30'd0, exp_gnt[k]});
            check($sformatf("t3_ack%0d", k), {30'd0, ack},
                  {30'd0, exp_ack[k]});
            check($sformatf("t3_rd%0d", k), {24'd0, rdata},
                  {24'd0, exp_rd[k]});
        end
        req = '0;
        step();

        // 4: single held requester
        set_req(1, 1'b1, 1'b0, 8'h20, 8'h00);
        exp_gnt = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        exp_ack = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00};
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("t4_gnt%0d", k), {30'd0, gnt},
                  {30'd0, exp_gnt[k]});
            check($sformatf("t4_ack%0d", k), {30'd0, ack},
                  {30'd0, exp_ack[k]});
        end
        req = '0;
        step();

        // Pointer vs fixed priority: serve req0 alone, then both
        set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
        step();
        step();
        req = '0;
        step();
        set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
        set_req(1, 1'b1, 1'b0, 8'h20, 8'h00);
        step();
`ifdef MEM_ARB_FIXED_PRIO_EN
        check("prio_first",  {30'd0, gnt}, 32'd1);
        step();
        check("prio_second", {30'd0, gnt}, 32'd2);
`else
        check("prio_first",  {30'd0, gnt}, 32'd2);
        step();
        check("prio_second", {30'd0, gnt}, 32'd1);
`endif
        step();
        check("prio_gap", {30'd0, gnt}, 32'd0);
        req = '0;
        step();

        // 5: reset during write ACCESS
        set_req(0, 1'b1, 1'b1, 8'h40, 8'h99);
        step();
        check("t5_gnt", {30'd0, gnt}, 32'd1);
        rst = 1'b1;
        #1;
        check("t5_mw", {31'd0, mem_write}, 32'd0);
        step();
        check("t5_gnt0",  {30'd0, gnt}, 32'd0);
        check("t5_ack0",  {30'd0, ack}, 32'd0);
        check("t5_rdata", {24'd0, rdata}, 32'd0);
        check("t5_ram",   {24'd0, ram[8'h40]}, 32'h77);
        req = '0;
        we  = '0;
        rst = 1'b0;
        step();
        check("t5_post_ack", {30'd0, ack}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
